alu_iter: RTL



---
 rtl/alu_iter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_iter.sv
// ---------------------------------------------------------------------------
// alu_iter: multi-cycle execute-stage ALU with valid/ready on both sides.
// Single-cycle ops (add/sub/logic/compare/zero-amount shift) answer one cycle
// after accept. Shifts move one bit per cycle. MUL is a fixed WIDTH-step
// shift-add that keeps the low half of the product. Illegal opcodes return
// zero with out_err set.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      request handshake; opcode/left/right sampled on accept
//   opcode[3:0]              {alt, funct3}
//   left, right [WIDTH-1:0]  operands A and B
//   out_valid / out_ready    result handshake
//   result [WIDTH-1:0]       registered result, held while out_valid
//   out_err                  illegal opcode flag, qualified by out_valid
// ---------------------------------------------------------------------------
module alu_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             out_err
);

   localparam int unsigned SHW = $clog2(WIDTH);
   // Counter must hold WIDTH itself for MUL.
   localparam int unsigned CW  = SHW + 1;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SRA  = 4'b1101;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1001;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      K_SLL = 2'd0,
      K_SRL = 2'd1,
      K_SRA = 2'd2,
      K_MUL = 2'd3
   } kind_t;

   state_t           r_state;
   state_t           w_state_nxt;
   kind_t            r_kind;
   logic [WIDTH-1:0] r_work;     // shift operand, or multiplicand for MUL
   logic [WIDTH-1:0] r_mplr;
   logic [WIDTH-1:0] r_acc;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_result;
   logic             r_err;

   logic             w_accept;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_fast;
   logic             w_err;
   logic             w_iter;
   kind_t            w_kind;
   logic [WIDTH-1:0] w_work_nxt;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0] w_exec_res;
   logic             w_last;

   assign w_accept = in_valid && in_ready;
   assign w_shamt  = right[SHW-1:0];

   // Opcode decode and single-cycle datapath.
   always_comb begin
      w_fast = '0;
      w_err  = 1'b0;
      w_iter = 1'b0;
      w_kind = K_SLL;
      case (opcode)
         OP_ADD:  w_fast = left + right;
         OP_SUB:  w_fast = left - right;
         OP_XOR:  w_fast = left ^ right;
         OP_OR:   w_fast = left | right;
         OP_AND:  w_fast = left & right;
         OP_SLT:  w_fast = WIDTH'($signed(left) < $signed(right));
         OP_SLTU: w_fast = WIDTH'(left < right);
         // Zero-amount shifts finish immediately with left unchanged.
         OP_SLL: begin
            w_kind = K_SLL;
            w_iter = |w_shamt;
            w_fast = left;
         end
         OP_SRL: begin
            w_kind = K_SRL;
            w_iter = |w_shamt;
            w_fast = left;
         end
         OP_SRA: begin
            w_kind = K_SRA;
            w_iter = |w_shamt;
            w_fast = left;
         end
         OP_MUL: begin
            w_kind = K_MUL;
            w_iter = 1'b1;
         end
         default: begin
            w_fast = '0;
            w_err  = 1'b1;
         end
      endcase
   end

   // One iteration step of the shifter / shift-add multiplier.
   always_comb begin
      w_work_nxt = r_work;
      case (r_kind)
         K_SLL:   w_work_nxt = {r_work[WIDTH-2:0], 1'b0};
         K_SRL:   w_work_nxt = {1'b0, r_work[WIDTH-1:1]};
         K_SRA:   w_work_nxt = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
         K_MUL:   w_work_nxt = {r_work[WIDTH-2:0], 1'b0};
         default: w_work_nxt = r_work;
      endcase
   end

   assign w_acc_nxt  = r_acc + (r_mplr[0] ? r_work : '0);
   assign w_last     = (r_cnt == CW'(1));
   assign w_exec_res = (r_kind == K_MUL) ? w_acc_nxt : w_work_nxt;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_iter ? S_EXEC : S_DONE;
            end
         end
         S_EXEC: begin
            if (w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode.
   always_comb begin
      in_ready  = (r_state == S_IDLE) && !rst;
      out_valid = (r_state == S_DONE);
      result    = r_result;
      out_err   = r_err;
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_kind   <= K_SLL;
         r_work   <= '0;
         r_mplr   <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_kind <= w_kind;
                  r_work <= left;
                  r_mplr <= right;
                  r_acc  <= '0;
                  r_cnt  <= (w_kind == K_MUL) ? CW'(WIDTH) : CW'(w_shamt);
                  r_err  <= w_err;
                  if (!w_iter) begin
                     r_result <= w_fast;
                  end
               end
            end
            S_EXEC: begin
               r_work <= w_work_nxt;
               r_mplr <= r_mplr >> 1;
               r_acc  <= w_acc_nxt;
               r_cnt  <= r_cnt - CW'(1);
               if (w_last) begin
                  r_result <= w_exec_res;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
